projectile_arbiter: RTL

- Shared projectile pool for the two-player tank game. Accepts fire requests from player 1 and player 2, allocates free projectile slots with round-robin arbitration under contention, and steps each live projectile once per frame along its launch direction.
- Frees a projectile when it would leave the playfield.
- Sits between the per-player tank objects (position/direction) and the colour mapper, which draws from the packed slot outputs.

---
 rtl/projectile_arbiter.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/projectile_arbiter.sv
// projectile_arbiter: shared projectile pool for two tanks with round-robin slot allocation and per-frame motion.
// Optional feature macro HIT_DETECT_EN frees bullets that strike the opposing tank and pulses hit1/hit2.
module projectile_arbiter #(
  parameter int NUM_SLOTS = 4,
  parameter int STEP      = 4,
  parameter int TANK_SIZE = 4,
  parameter int X_MIN     = 1,
  parameter int X_MAX     = 639,
  parameter int Y_MIN     = 1,
  parameter int Y_MAX     = 479,
  parameter int COOLDOWN  = 15
) (
  input  logic                   frame_clk,
  input  logic                   Reset_n,
  input  logic                   fire_req1,
  input  logic                   fire_req2,
  input  logic [9:0]             tank1_x,
  input  logic [9:0]             tank1_y,
  input  logic [9:0]             tank2_x,
  input  logic [9:0]             tank2_y,
  input  logic [1:0]             tank1_dir,
  input  logic [1:0]             tank2_dir,
  output logic                   fire_ack1,
  output logic                   fire_ack2,
  output logic [NUM_SLOTS-1:0]   slot_valid,
  output logic [10*NUM_SLOTS-1:0] slot_x,
  output logic [10*NUM_SLOTS-1:0] slot_y,
  output logic [NUM_SLOTS-1:0]   slot_owner,
  output logic                   hit1,
  output logic                   hit2
);
  localparam int CW = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN + 1);
  localparam int SW = $clog2(NUM_SLOTS);
  localparam logic [11:0] OFF        = 12'(TANK_SIZE + 1);
  localparam logic [11:0] XLO        = 12'(X_MIN);
  localparam logic [11:0] XHI        = 12'(X_MAX);
  localparam logic [11:0] YLO        = 12'(Y_MIN);
  localparam logic [11:0] YHI        = 12'(Y_MAX);
  localparam logic [11:0] LEFT_EXIT  = 12'(X_MIN + STEP);
  localparam logic [11:0] RIGHT_EXIT = 12'(X_MAX - STEP);
  localparam logic [11:0] UP_EXIT    = 12'(Y_MIN + STEP);
  localparam logic [11:0] DOWN_EXIT  = 12'(Y_MAX - STEP);
  localparam logic [9:0]  STEP10     = 10'(STEP);

  typedef enum logic [1:0] {DIR_LEFT = 2'b00, DIR_RIGHT = 2'b01, DIR_DOWN = 2'b10, DIR_UP = 2'b11} dir_t;
  typedef struct packed { logic ok; logic [9:0] x; logic [9:0] y; } spawn_t;

  // 12-bit working width so neither the offset nor the bounds compare can wrap.
  function automatic spawn_t spawn_calc(input logic [9:0] x, input logic [9:0] y, input logic [1:0] dir);
    spawn_t s;
    logic [11:0] sx, sy;
    logic ok;
    sx = {2'b00, x};
    sy = {2'b00, y};
    ok = 1'b1;
    case (dir_t'(dir))
      DIR_LEFT:  if (sx >= OFF) sx = sx - OFF; else ok = 1'b0;
      DIR_RIGHT: sx = sx + OFF;
      DIR_DOWN:  sy = sy + OFF;
      default:   if (sy >= OFF) sy = sy - OFF; else ok = 1'b0;
    endcase
    s.ok = ok && (sx >= XLO) && (sx <= XHI) && (sy >= YLO) && (sy <= YHI);
    s.x  = sx[9:0];
    s.y  = sy[9:0];
    return s;
  endfunction

`ifdef HIT_DETECT_EN
  localparam logic [11:0] TS12 = 12'(TANK_SIZE);

  function automatic logic near(input logic [9:0] bx, input logic [9:0] by,
                                input logic [9:0] tx, input logic [9:0] ty);
    return ({2'b00, bx} + TS12 >= {2'b00, tx}) && ({2'b00, bx} <= {2'b00, tx} + TS12) &&
           ({2'b00, by} + TS12 >= {2'b00, ty}) && ({2'b00, by} <= {2'b00, ty} + TS12);
  endfunction

  logic hit1_next, hit2_next;
`endif

  logic req_prev1, req_prev2, pending1, pending2, rr_ptr;
  logic [CW-1:0] cool1, cool2;
  logic [2*NUM_SLOTS-1:0] slot_dir;

  logic rise1, rise2, elig1, elig2, go1, go2, drop1, drop2;
  logic grant1, grant2, have1, have2, rr_next, struck;
  logic pending1_next, pending2_next;
  logic [CW-1:0] cool1_next, cool2_next;
  logic [SW-1:0] idx_a, idx_b, idx2;
  logic [11:0] cx, cy;
  spawn_t sp1, sp2;
  logic [NUM_SLOTS-1:0] valid_next, owner_next;
  logic [10*NUM_SLOTS-1:0] x_next, y_next;
  logic [2*NUM_SLOTS-1:0] dir_next;

  always_comb begin
    rise1 = fire_req1 & ~req_prev1;
    rise2 = fire_req2 & ~req_prev2;
    sp1   = spawn_calc(tank1_x, tank1_y, tank1_dir);
    sp2   = spawn_calc(tank2_x, tank2_y, tank2_dir);
    elig1 = pending1 && (cool1 == '0);
    elig2 = pending2 && (cool2 == '0);
    go1   = elig1 && sp1.ok;
    go2   = elig2 && sp2.ok;
    drop1 = elig1 && !sp1.ok;
    drop2 = elig2 && !sp2.ok;

    // Only slots idle at the start of this frame are candidates; exits this frame free up next frame.
    have1 = 1'b0;
    have2 = 1'b0;
    idx_a = '0;
    idx_b = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!slot_valid[i]) begin
        if (!have1) begin
          have1 = 1'b1;
          idx_a = SW'(i);
        end else if (!have2) begin
          have2 = 1'b1;
          idx_b = SW'(i);
        end
      end
    end

    grant1  = 1'b0;
    grant2  = 1'b0;
    idx2    = idx_a;
    rr_next = rr_ptr;
    if (go1 && go2) begin
      if (have2) begin
        grant1 = 1'b1;
        grant2 = 1'b1;
        idx2   = idx_b;
      end else if (have1) begin
        grant1  = ~rr_ptr;
        grant2  = rr_ptr;
        rr_next = ~rr_ptr;
      end
    end else begin
      grant1 = go1 && have1;
      grant2 = go2 && have1;
    end

    pending1_next = rise1 | (pending1 & ~grant1 & ~drop1);
    pending2_next = rise2 | (pending2 & ~grant2 & ~drop2);
    cool1_next    = grant1 ? CW'(COOLDOWN) : ((cool1 != '0) ? cool1 - CW'(1) : '0);
    cool2_next    = grant2 ? CW'(COOLDOWN) : ((cool2 != '0) ? cool2 - CW'(1) : '0);

    valid_next = slot_valid;
    owner_next = slot_owner;
    x_next     = slot_x;
    y_next     = slot_y;
    dir_next   = slot_dir;
    cx         = '0;
    cy         = '0;
    struck     = 1'b0;
`ifdef HIT_DETECT_EN
    hit1_next  = 1'b0;
    hit2_next  = 1'b0;
`endif
    for (int i = 0; i < NUM_SLOTS; i++) begin
      cx     = {2'b00, slot_x[10*i +: 10]};
      cy     = {2'b00, slot_y[10*i +: 10]};
      struck = 1'b0;
`ifdef HIT_DETECT_EN
      if (slot_valid[i]) begin
        if (slot_owner[i]) begin
          struck    = near(slot_x[10*i +: 10], slot_y[10*i +: 10], tank1_x, tank1_y);
          hit1_next = hit1_next | struck;
        end else begin
          struck    = near(slot_x[10*i +: 10], slot_y[10*i +: 10], tank2_x, tank2_y);
          hit2_next = hit2_next | struck;
        end
      end
`endif
      if (slot_valid[i]) begin
        if (struck) begin
          valid_next[i] = 1'b0;
        end else begin
          case (dir_t'(slot_dir[2*i +: 2]))
            DIR_LEFT:  if (cx < LEFT_EXIT)  valid_next[i] = 1'b0; else x_next[10*i +: 10] = slot_x[10*i +: 10] - STEP10;
            DIR_RIGHT: if (cx > RIGHT_EXIT) valid_next[i] = 1'b0; else x_next[10*i +: 10] = slot_x[10*i +: 10] + STEP10;
            DIR_DOWN:  if (cy > DOWN_EXIT)  valid_next[i] = 1'b0; else y_next[10*i +: 10] = slot_y[10*i +: 10] + STEP10;
            default:   if (cy < UP_EXIT)    valid_next[i] = 1'b0; else y_next[10*i +: 10] = slot_y[10*i +: 10] - STEP10;
          endcase
        end
      end
      if (grant1 && (idx_a == SW'(i))) begin
        valid_next[i]        = 1'b1;
        owner_next[i]        = 1'b0;
        x_next[10*i +: 10]   = sp1.x;
        y_next[10*i +: 10]   = sp1.y;
        dir_next[2*i +: 2]   = tank1_dir;
      end
      if (grant2 && (idx2 == SW'(i))) begin
        valid_next[i]        = 1'b1;
        owner_next[i]        = 1'b1;
        x_next[10*i +: 10]   = sp2.x;
        y_next[10*i +: 10]   = sp2.y;
        dir_next[2*i +: 2]   = tank2_dir;
      end
    end
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      req_prev1  <= 1'b0;
      req_prev2  <= 1'b0;
      pending1   <= 1'b0;
      pending2   <= 1'b0;
      cool1      <= '0;
      cool2      <= '0;
      rr_ptr     <= 1'b0;
      fire_ack1  <= 1'b0;
      fire_ack2  <= 1'b0;
      slot_valid <= '0;
      slot_owner <= '0;
      slot_x     <= '0;
      slot_y     <= '0;
      slot_dir   <= '0;
    end else begin
      req_prev1  <= fire_req1;
      req_prev2  <= fire_req2;
      pending1   <= pending1_next;
      pending2   <= pending2_next;
      cool1      <= cool1_next;
      cool2      <= cool2_next;
      rr_ptr     <= rr_next;
      fire_ack1  <= grant1;
      fire_ack2  <= grant2;
      slot_valid <= valid_next;
      slot_owner <= owner_next;
      slot_x     <= x_next;
      slot_y     <= y_next;
      slot_dir   <= dir_next;
    end
  end

`ifdef HIT_DETECT_EN
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hit1 <= 1'b0;
      hit2 <= 1'b0;
    end else begin
      hit1 <= hit1_next;
      hit2 <= hit2_next;
    end
  end
`else
  assign hit1 = 1'b0;
  assign hit2 = 1'b0;
`endif

endmodule
